filt_mac: RTL

Sequential bipolar FIR accumulator that sits directly downstream of the `filt` bit-capture stage. On each `FILTER` pulse it snapshots the TAPS-bit window held in that stage's second buffer. It then walks the window one tap per cycle, adding `+coef[i]` for a 1 bit and `-coef[i]` for a 0 bit, and presents the signed sum as one filtered sample with a single-cycle valid strobe. Coefficients live in a local register file that is written through a simple word-write port.

---
 rtl/filt_mac.sv | 111 +++++++++++
 1 files changed

// File: rtl/filt_mac.sv
// filt_mac: sequential bipolar FIR accumulator behind the filt capture stage.
// Snapshots the capture window and adds +coef/-coef per tap bit, one tap a cycle.
module filt_mac #(
  parameter int TAPS   = 32,
  parameter int COEF_W = 12,
  parameter int ACC_W  = COEF_W + $clog2(TAPS) + 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     FILTER,
  input  logic [TAPS-1:0]          Window,
  input  logic                     CoefWe,
  input  logic [$clog2(TAPS)-1:0]  CoefAddr,
  input  logic [COEF_W-1:0]        CoefData,
  output logic [ACC_W-1:0]         Output,
  output logic                     OutValid,
  output logic                     Busy,
  output logic                     Overrun
);

  localparam int IW  = $clog2(TAPS);
  localparam int EXT = ACC_W - COEF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_start;
  logic                w_busy;
  logic                w_last;
  logic [TAPS-1:0]     r_snap;
  logic [IW-1:0]       r_idx;
  logic [ACC_W-1:0]    r_acc;
  logic [COEF_W-1:0]   r_coef [TAPS];
  logic [COEF_W-1:0]   w_coef;
  logic [ACC_W-1:0]    w_term;
  logic [ACC_W-1:0]    w_add;

  assign w_busy = (r_state != S_IDLE);
  assign Busy   = w_busy;
  assign w_last = (r_idx == IW'(TAPS - 1));
  assign w_coef = r_coef[r_idx];
  assign w_term = {{EXT{w_coef[COEF_W-1]}}, w_coef};
  assign w_add  = r_snap[r_idx] ? w_term : -w_term;

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state; a start is only taken from IDLE.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (FILTER) begin
          w_next  = S_ACCUM;
          w_start = 1'b1;
        end
      end
      S_ACCUM: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Coefficient file; writes while busy are dropped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if (CoefWe && !w_busy) begin
      r_coef[CoefAddr] <= CoefData;
    end
  end

  // Snapshot, tap walk and accumulation.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_snap <= '0;
      r_idx  <= '0;
      r_acc  <= '0;
    end else if (w_start) begin
      r_snap <= Window;
      r_idx  <= '0;
      r_acc  <= '0;
    end else if (r_state == S_ACCUM) begin
      r_idx  <= r_idx + 1'b1;
      r_acc  <= r_acc + w_add;
    end
  end

  // Result register and status pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Output   <= '0;
      OutValid <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      OutValid <= (r_state == S_DONE);
      Overrun  <= FILTER && w_busy;
      if (r_state == S_DONE) Output <= r_acc;
    end
  end

endmodule
